// File: rtl/pipeline_hazard_ctrl_if.sv
// Status/control bundle between the 5-stage pipeline datapath and its hazard sequencer.
// The slave side is the sequencer; the master side is the datapath that obeys the controls.
interface pipeline_hazard_ctrl_if #(
  parameter int REGW = 5,
  parameter int CNTW = 32
);
  logic            ihit, dhit;
  logic [REGW-1:0] ifid_rs, ifid_rt;
  logic            ifid_uses_rt;
  logic            idex_dREN;
  logic [REGW-1:0] idex_rt;
  logic            exmem_dREN, exmem_dWEN;
  logic            ex_redirect;
  logic            memwb_halt;
  logic            pc_en;
  logic            ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic            halt;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_dREN, idex_rt,
           exmem_dREN, exmem_dWEN, ex_redirect, memwb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, stall_cnt
  );

  modport slave (
    input  ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_dREN, idex_rt,
           exmem_dREN, exmem_dWEN, ex_redirect, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline: latch enables/flushes,
// PC enable, sticky halt and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int REGW        = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNTW        = 32
) (
  input logic CLK,
  input logic RST,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMWAIT = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;
  localparam logic       REDIR_IDEX = (FLUSH_DEPTH == 2);

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            mem_busy, load_use;
  logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, exmem_flush, memwb_flush;

  assign mem_busy = (hz.exmem_dREN | hz.exmem_dWEN) & ~hz.dhit;
  // r0 is hardwired zero, so a load targeting it never creates a real dependency
  assign load_use = hz.idex_dREN & (hz.idex_rt != '0) &
                    ((hz.idex_rt == hz.ifid_rs) | (hz.ifid_uses_rt & (hz.idex_rt == hz.ifid_rt)));

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.memwb_halt) begin
          state_d = HALTED;
        end else if (mem_busy) begin
          state_d     = MEMWAIT;
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end else if (hz.ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = REDIR_IDEX;
        end else if (load_use) begin
          // holding IF/ID takes precedence over bubbling it on a concurrent fetch miss
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!hz.ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      MEMWAIT: begin
        if (!hz.dhit) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      HALTED: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      default: state_d = RUN;
    endcase
    if (RST) begin
      state_d  = RUN;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (state_q != HALTED) && (stall_cnt_q != {CNTW{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.idex_en     = idex_en;
  assign hz.exmem_en    = exmem_en;
  assign hz.memwb_en    = memwb_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.memwb_flush = memwb_flush;
  assign hz.halt        = (state_q == HALTED);
  assign hz.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: three sequencer builds (default, single-stage redirect flush, 4-bit counter)
// driven by the same stimulus, each check hand-derived.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       ihit, dhit, ifid_uses_rt, idex_dREN, exmem_dREN, exmem_dWEN, ex_redirect, memwb_halt;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REGW(5), .CNTW(32)) ha ();
  pipeline_hazard_ctrl_if #(.REGW(5), .CNTW(32)) hb ();
  pipeline_hazard_ctrl_if #(.REGW(5), .CNTW(4))  hc ();

  assign ha.ihit = ihit;  assign hb.ihit = ihit;  assign hc.ihit = ihit;
  assign ha.dhit = dhit;  assign hb.dhit = dhit;  assign hc.dhit = dhit;
  assign ha.ifid_rs = ifid_rs;  assign hb.ifid_rs = ifid_rs;  assign hc.ifid_rs = ifid_rs;
  assign ha.ifid_rt = ifid_rt;  assign hb.ifid_rt = ifid_rt;  assign hc.ifid_rt = ifid_rt;
  assign ha.ifid_uses_rt = ifid_uses_rt;  assign hb.ifid_uses_rt = ifid_uses_rt;  assign hc.ifid_uses_rt = ifid_uses_rt;
  assign ha.idex_dREN = idex_dREN;  assign hb.idex_dREN = idex_dREN;  assign hc.idex_dREN = idex_dREN;
  assign ha.idex_rt = idex_rt;  assign hb.idex_rt = idex_rt;  assign hc.idex_rt = idex_rt;
  assign ha.exmem_dREN = exmem_dREN;  assign hb.exmem_dREN = exmem_dREN;  assign hc.exmem_dREN = exmem_dREN;
  assign ha.exmem_dWEN = exmem_dWEN;  assign hb.exmem_dWEN = exmem_dWEN;  assign hc.exmem_dWEN = exmem_dWEN;
  assign ha.ex_redirect = ex_redirect;  assign hb.ex_redirect = ex_redirect;  assign hc.ex_redirect = ex_redirect;
  assign ha.memwb_halt = memwb_halt;  assign hb.memwb_halt = memwb_halt;  assign hc.memwb_halt = memwb_halt;

  pipeline_hazard_ctrl #(.REGW(5), .FLUSH_DEPTH(2), .CNTW(32)) dut     (.CLK(clk), .RST(rst), .hz(ha));
  pipeline_hazard_ctrl #(.REGW(5), .FLUSH_DEPTH(1), .CNTW(32)) dut_fd1 (.CLK(clk), .RST(rst), .hz(hb));
  pipeline_hazard_ctrl #(.REGW(5), .FLUSH_DEPTH(2), .CNTW(4))  dut_sat (.CLK(clk), .RST(rst), .hz(hc));

  // {pc, ifid, idex, exmem, memwb} enables and {ifid, idex, exmem, memwb} flushes
  wire [4:0] en_a = {ha.pc_en, ha.ifid_en, ha.idex_en, ha.exmem_en, ha.memwb_en};
  wire [3:0] fl_a = {ha.ifid_flush, ha.idex_flush, ha.exmem_flush, ha.memwb_flush};
  wire [4:0] en_b = {hb.pc_en, hb.ifid_en, hb.idex_en, hb.exmem_en, hb.memwb_en};
  wire [3:0] fl_b = {hb.ifid_flush, hb.idex_flush, hb.exmem_flush, hb.memwb_flush};

  task automatic quiet();
    rst = 1'b0; ihit = 1'b1; dhit = 1'b1; ifid_uses_rt = 1'b0; idex_dREN = 1'b0;
    exmem_dREN = 1'b0; exmem_dWEN = 1'b0; ex_redirect = 1'b0; memwb_halt = 1'b0;
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
  endtask

  // drive on the falling edge; checks follow 2 time units later
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(); quiet(); rst = 1'b1;
    cyc(); quiet();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc();
      rst = 1'b1; ihit = 1'($urandom); dhit = 1'($urandom); memwb_halt = 1'($urandom);
      exmem_dREN = 1'($urandom); ex_redirect = 1'($urandom); idex_dREN = 1'($urandom);
      idex_rt = 5'($urandom); ifid_rs = 5'($urandom);
      #2;
      checks++; if (en_a !== 5'b00000) begin errors++; $display("FAIL reset_en[%0d]: got %b want 00000", i, en_a); end
      checks++; if (fl_a !== 4'b0000) begin errors++; $display("FAIL reset_flush[%0d]: got %b want 0000", i, fl_a); end
      if (i == 1) begin
        checks++; if (ha.halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", ha.halt); end
        checks++; if (ha.stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", ha.stall_cnt); end
      end
    end
    cyc(); quiet(); #2;
    checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL post_reset_en: got %b want 11111", en_a); end
    checks++; if (fl_a !== 4'b0000) begin errors++; $display("FAIL post_reset_flush: got %b want 0000", fl_a); end
    checks++; if (ha.stall_cnt !== 32'd0) begin errors++; $display("FAIL post_reset_cnt: got %0d want 0", ha.stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; #2;
    checks++; if (en_a !== 5'b00111) begin errors++; $display("FAIL lu_en: got %b want 00111", en_a); end
    checks++; if (fl_a !== 4'b0100) begin errors++; $display("FAIL lu_flush: got %b want 0100", fl_a); end
    cyc(); quiet(); ifid_rs = 5'd5; #2;  // load left EX, a bubble is there now
    checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL lu_release_en: got %b want 11111", en_a); end
    checks++; if (ha.stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", ha.stall_cnt); end
    cyc(); quiet(); idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; #2;
    checks++; if (en_a !== 5'b11111 || fl_a !== 4'b0000) begin errors++; $display("FAIL lu_r0: got %b/%b want 11111/0000", en_a, fl_a); end
    cyc(); quiet(); idex_dREN = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; ifid_uses_rt = 1'b1; #2;
    checks++; if (en_a !== 5'b00111 || fl_a !== 4'b0100) begin errors++; $display("FAIL lu_rt: got %b/%b want 00111/0100", en_a, fl_a); end
    ifid_uses_rt = 1'b0; #2;
    checks++; if (en_a !== 5'b11111 || fl_a !== 4'b0000) begin errors++; $display("FAIL lu_rt_unused: got %b/%b want 11111/0000", en_a, fl_a); end
    ifid_uses_rt = 1'b1; ihit = 1'b0; #2;
    checks++; if (en_a !== 5'b00111 || fl_a !== 4'b0100) begin errors++; $display("FAIL lu_vs_imiss: got %b/%b want 00111/0100", en_a, fl_a); end
    cyc(); quiet(); ihit = 1'b0; #2;
    checks++; if (en_a !== 5'b01111 || fl_a !== 4'b1000) begin errors++; $display("FAIL imiss: got %b/%b want 01111/1000", en_a, fl_a); end
  endtask

  task automatic test_memwait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      quiet(); exmem_dREN = 1'b1; dhit = 1'b0;
      if (i == 1) ex_redirect = 1'b1;
      if (i == 2) memwb_halt = 1'b1;
      #2;
      checks++; if (en_a !== 5'b00001) begin errors++; $display("FAIL mw_en[%0d]: got %b want 00001", i, en_a); end
      checks++; if (fl_a !== 4'b0001) begin errors++; $display("FAIL mw_flush[%0d]: got %b want 0001", i, fl_a); end
    end
    cyc(); quiet(); exmem_dREN = 1'b1; dhit = 1'b1; #2;
    checks++; if (en_a !== 5'b11111 || fl_a !== 4'b0000) begin errors++; $display("FAIL mw_done: got %b/%b want 11111/0000", en_a, fl_a); end
    cyc(); quiet(); #2;
    checks++; if (ha.stall_cnt !== 32'd3) begin errors++; $display("FAIL mw_cnt: got %0d want 3", ha.stall_cnt); end
    checks++; if (ha.halt !== 1'b0 || en_a !== 5'b11111) begin errors++; $display("FAIL mw_back_run: got halt=%b en=%b want 0/11111", ha.halt, en_a); end
    exmem_dWEN = 1'b1; dhit = 1'b0; #2;
    checks++; if (en_a !== 5'b00001 || fl_a !== 4'b0001) begin errors++; $display("FAIL mw_store: got %b/%b want 00001/0001", en_a, fl_a); end
  endtask

  task automatic test_redirect();
    do_reset();
    ex_redirect = 1'b1; idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ihit = 1'b0; #2;
    checks++; if (en_a !== 5'b11111 || fl_a !== 4'b1100) begin errors++; $display("FAIL redir_fd2: got %b/%b want 11111/1100", en_a, fl_a); end
    checks++; if (en_b !== 5'b11111 || fl_b !== 4'b1000) begin errors++; $display("FAIL redir_fd1: got %b/%b want 11111/1000", en_b, fl_b); end
    cyc(); quiet(); #2;
    checks++; if (ha.stall_cnt !== 32'd0 || hb.stall_cnt !== 32'd0) begin errors++; $display("FAIL redir_cnt: got %0d/%0d want 0/0", ha.stall_cnt, hb.stall_cnt); end
    ex_redirect = 1'b1; exmem_dREN = 1'b1; dhit = 1'b0; #2;
    checks++; if (en_a !== 5'b00001 || fl_a !== 4'b0001) begin errors++; $display("FAIL redir_vs_mem: got %b/%b want 00001/0001", en_a, fl_a); end
  endtask

  task automatic test_halt();
    do_reset();
    ihit = 1'b0; cyc(); cyc(); quiet();
    memwb_halt = 1'b1; #2;
    checks++; if (en_a !== 5'b11111 || ha.halt !== 1'b0) begin errors++; $display("FAIL halt_entry: got en=%b halt=%b want 11111/0", en_a, ha.halt); end
    for (int i = 0; i < 10; i++) begin
      cyc(); quiet(); ihit = i[0]; dhit = i[1]; ex_redirect = i[2]; exmem_dREN = 1'b1; #2;
      checks++; if (ha.halt !== 1'b1 || en_a !== 5'b00000 || fl_a !== 4'b0000) begin errors++; $display("FAIL halt_hold[%0d]: got halt=%b en=%b fl=%b want 1/00000/0000", i, ha.halt, en_a, fl_a); end
    end
    checks++; if (ha.stall_cnt !== 32'd2) begin errors++; $display("FAIL halt_cnt: got %0d want 2", ha.stall_cnt); end
    cyc(); quiet(); rst = 1'b1;
    cyc(); quiet(); #2;
    checks++; if (ha.halt !== 1'b0 || en_a !== 5'b11111) begin errors++; $display("FAIL halt_exit: got halt=%b en=%b want 0/11111", ha.halt, en_a); end
  endtask

  task automatic test_saturation();
    do_reset();
    ihit = 1'b0;
    repeat (20) cyc();
    quiet(); #2;
    checks++; if (hc.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", hc.stall_cnt); end
    checks++; if (ha.stall_cnt !== 32'd20) begin errors++; $display("FAIL sat_cnt32: got %0d want 20", ha.stall_cnt); end
  endtask

  initial begin
    quiet();
    test_reset();
    test_load_use();
    test_memwait();
    test_redirect();
    test_halt();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives per-latch enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC enable.
- Resolves, in one place: load-use hazards, instruction-fetch misses, data-memory waits, EX-stage control redirects and program halt.
- Keeps a saturating stall-cycle performance counter.

Parameters:
REGW, 5, register-specifier width
FLUSH_DEPTH, 2, stages squashed on EX redirect (1 = IF/ID only; 2 = IF/ID and ID/EX)
CNTW, 32, stall counter width

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
ihit  input  1  instruction fetch completes this cycle
dhit  input  1  data access completes this cycle
ifid_rs  input  REGW  rs of instruction in ID
ifid_rt  input  REGW  rt of instruction in ID
ifid_uses_rt  input  1  ID instruction reads rt as a source
idex_dREN  input  1  instruction in EX is a load
idex_rt  input  REGW  destination rt of instruction in EX
exmem_dREN  input  1  MEM-stage read
exmem_dWEN  input  1  MEM-stage write
ex_redirect  input  1  taken branch/jump/jr resolved in EX
memwb_halt  input  1  halt instruction reached WB latch
pc_en  output  1  PC loads next value
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch captures input
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  latch captures all-zero bubble (valid only with matching en=1)
halt  output  1  sticky processor halted
stall_cnt  output  CNTW  cycles with pc_en=0 while not halted

Behaviour:
- States: RUN, MEMWAIT, HALTED. Registered state; outputs are combinational from state and inputs.
- Reset (RST=1 at edge): state=RUN, stall_cnt=0, halt=0.
- Reset mid-MEMWAIT or mid-HALTED returns to RUN next cycle.
- During the RST cycle, all en=0 and all flush=0.
- Flush is never asserted with its en=0. Default in RUN: all en=1, all flush=0.
- Condition priority in RUN, highest first:
  1. memwb_halt -> next HALTED.
  2. (exmem_dREN|exmem_dWEN) & !dhit -> next MEMWAIT. This cycle: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1, memwb_flush=1.
  3. ex_redirect -> pc_en=1 (target load), ifid_flush=1; idex_flush=1 iff FLUSH_DEPTH==2. Overrides load-use and ihit=0 in the same cycle.
  4. Load-use: idex_dREN & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)) -> pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble, because the load advances out of EX.
  5. !ihit -> pc_en=0, ifid_flush=1. ID/EX and later advance.
- Load-use and !ihit in the same cycle: the load-use controls apply; ifid_en=0 wins and ifid_flush=0.
- MEMWAIT: same freeze outputs as condition 2 while dhit=0.
  - dhit=1 -> all en=1, next RUN.
  - ex_redirect and load-use are held by the frozen latches and are re-evaluated in RUN.
  - memwb_halt in MEMWAIT is ignored; it cannot occur, because MEM/WB is receiving bubbles.
- HALTED: halt=1, all en=0, all flush=0. Exit only via RST.
- stall_cnt: +1 on each edge where pc_en=0, state!=HALTED and RST=0. Saturates at 2^CNTW-1; no wrap.
- Register 0 never causes a load-use stall.

Test Plan:
- Reset: RST=1 for 2 cycles with random inputs -> halt=0, stall_cnt=0, all en=0. First cycle after release with quiet inputs -> all en=1, flush=0.
- Load-use: idex_dREN=1, idex_rt=5, ifid_rs=5, ihit=1 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with idex_rt=0 -> no stall.
- Memory wait: exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of freeze with memwb_flush=1, then all en=1; stall_cnt=3.
- Redirect vs hazards: ex_redirect=1 with load-use match and ihit=0, FLUSH_DEPTH=2 -> pc_en=1, ifid_flush=1, idex_flush=1. With FLUSH_DEPTH=1 -> idex_flush=0, idex_en=1.
- Halt: memwb_halt=1 -> next cycle halt=1, all en=0, held 10 cycles despite ihit/dhit toggling, stall_cnt unchanged. RST=1 -> RUN.
- Saturation: CNTW=4, ihit=0 for 20 cycles -> stall_cnt stops at 15.
